// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// Button-driven LED pattern controller. A free-running prescaler produces a
// one-cycle TICK; each accepted button press advances the display mode
// COUNT -> SCAN -> BLINK -> MIRROR -> COUNT. The selected mode steps the
// 8-bit LED pattern once per TICK (MIRROR follows the switches every cycle).
// SW[0] pauses the stepping in COUNT, SCAN and BLINK.
//
// Build option:
//   LED_PATTERN_DEBOUNCE_EN  when defined, the synchronized button is only
//                            accepted after DEBOUNCE_TICKS consecutive equal
//                            samples taken at prescaler wraps. When undefined,
//                            the synchronized button is used directly.
//
// Parameters:
//   PRESCALE_BITS   prescaler width, TICK period is 2**PRESCALE_BITS (>= 2)
//   DEBOUNCE_TICKS  stable wrap samples needed to accept a level (2..15)
//
// Ports:
//   CLK     single clock for all logic
//   RST     asynchronous, active-high reset
//   BUTTON  raw pushbutton, active-high, asynchronous to CLK
//   SW      slide switches, asynchronous to CLK
//   LED     registered LED pattern
//   MODE    registered mode (0 COUNT, 1 SCAN, 2 BLINK, 3 MIRROR)
//   TICK    one-cycle pulse following each prescaler wrap
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
  parameter int PRESCALE_BITS  = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BUTTON,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  output logic [1:0] MODE,
  output logic       TICK
);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_MIRROR = 2'd3
  } mode_e;

  localparam logic [PRESCALE_BITS-1:0] PRESCALE_ONE = 1;

  // ---------------------------------------------------------------------------
  // Prescaler. `wrap` is high on the last count; TICK is its registered copy,
  // so TICK is high during the cycle in which the prescaler reads zero.
  // ---------------------------------------------------------------------------
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic                     wrap;

  assign wrap = &prescale_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescale_q <= '0;
      TICK       <= 1'b0;
    end else begin
      prescale_q <= prescale_q + PRESCALE_ONE;
      TICK       <= wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous inputs.
  // ---------------------------------------------------------------------------
  logic       btn_meta, btn_sync;
  logic [3:0] sw_meta, sw_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      sw_meta  <= 4'h0;
      sw_sync  <= 4'h0;
    end else begin
      btn_meta <= BUTTON;
      btn_sync <= btn_meta;
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Press arming. The synchronizer reads zero for its first cycles after
  // reset, which would fake a rising edge if the button is held across reset
  // release. Presses are only honoured once the synchronized button has been
  // seen released after the synchronizer has settled.
  // ---------------------------------------------------------------------------
  logic [1:0] settle_cnt;
  logic       settled;
  logic       armed;

  assign settled = &settle_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (!settled) settle_cnt <= settle_cnt + 2'd1;
      armed <= armed | (settled & ~btn_sync);
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted button level and rising-edge detection.
  // ---------------------------------------------------------------------------
  logic press_rise;
  logic press_q;

`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  logic       btn_level;
  logic [3:0] db_cnt;

  // db_cnt counts consecutive wrap samples that differ from the accepted
  // level; a sample that agrees with the accepted level restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_level <= 1'b0;
      db_cnt    <= 4'd0;
    end else if (wrap) begin
      if (btn_sync == btn_level) begin
        db_cnt <= 4'd0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= btn_sync;
        db_cnt    <= 4'd0;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end
  end

  // Rising edge is the wrap on which a high level gets accepted.
  assign press_rise = wrap & btn_sync & ~btn_level & (db_cnt == DB_LAST);
`else
  logic btn_prev;
  logic unused_debounce;

  // DEBOUNCE_TICKS has no role without the debouncer.
  assign unused_debounce = (DEBOUNCE_TICKS > 0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) btn_prev <= 1'b0;
    else     btn_prev <= btn_sync;
  end

  assign press_rise = btn_sync & ~btn_prev;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) press_q <= 1'b0;
    else     press_q <= press_rise & armed;
  end

  // ---------------------------------------------------------------------------
  // Mode FSM and LED pattern.
  // ---------------------------------------------------------------------------
  mode_e      mode_q, mode_d;
  logic [7:0] led_q, led_d;
  logic       scan_left_q, scan_left_d;
  logic       step;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q      <= MODE_COUNT;
      led_q       <= 8'h00;
      scan_left_q <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      led_q       <= led_d;
      scan_left_q <= scan_left_d;
    end
  end

  assign step = TICK & ~sw_sync[0];

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    mode_d      = mode_q;
    led_d       = led_q;
    scan_left_d = scan_left_q;

    if (press_q) begin
      // A press wins over a coincident TICK: only the entry value is loaded.
      scan_left_d = 1'b1;
      unique case (mode_q)
        MODE_COUNT:  begin mode_d = MODE_SCAN;   led_d = 8'h01;              end
        MODE_SCAN:   begin mode_d = MODE_BLINK;  led_d = 8'h00;              end
        MODE_BLINK:  begin mode_d = MODE_MIRROR; led_d = {sw_sync, sw_sync}; end
        MODE_MIRROR: begin mode_d = MODE_COUNT;  led_d = 8'h00;              end
        default:     begin mode_d = MODE_COUNT;  led_d = 8'h00;              end
      endcase
    end else begin
      unique case (mode_q)
        MODE_COUNT: begin
          if (step) led_d = led_q + 8'd1;
        end
        MODE_SCAN: begin
          if (step) begin
            if (scan_left_q) begin
              if (led_q == 8'h80) begin
                led_d       = 8'h40;
                scan_left_d = 1'b0;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q == 8'h01) begin
                led_d       = 8'h02;
                scan_left_d = 1'b1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
        end
        MODE_BLINK: begin
          if (step) led_d = ~led_q;
        end
        MODE_MIRROR: begin
          led_d = {sw_sync, sw_sync};
        end
        default: begin
          mode_d = MODE_COUNT;
          led_d  = 8'h00;
        end
      endcase
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Directed self-checking bench for led_pattern_ctrl with PRESCALE_BITS=2
// (TICK every 4 cycles) and DEBOUNCE_TICKS=2. Inputs change and outputs are
// sampled on the falling clock edge. Defining LED_PATTERN_DEBOUNCE_EN selects
// the debounce scenarios instead of the direct-button latency scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

  logic       CLK;
  logic       RST;
  logic       BUTTON;
  logic [3:0] SW;
  logic [7:0] LED;
  logic [1:0] MODE;
  logic       TICK;

  int checks = 0;
  int errors = 0;

  // Scan model state shared by the scan tasks.
  logic [7:0] exp_led;
  logic       scan_left;

  led_pattern_ctrl #(
    .PRESCALE_BITS (2),
    .DEBOUNCE_TICKS(2)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BUTTON(BUTTON),
    .SW    (SW),
    .LED   (LED),
    .MODE  (MODE),
    .TICK  (TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset(input logic btn);
    BUTTON = btn;
    SW     = 4'h0;
    RST    = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Raises the button and waits for the mode update, then checks it.
  task automatic press(input logic [1:0] exp_mode, input logic [7:0] exp_entry);
    logic [1:0] start;
    int n;
    start  = MODE;
    n      = 0;
    BUTTON = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (MODE === start && n < 60);
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL press_timeout: mode stayed %0d, want %0d", MODE, exp_mode);
    end
    checks++;
    if (MODE !== exp_mode) begin
      errors++;
      $display("FAIL press_mode: got %0d want %0d", MODE, exp_mode);
    end
    checks++;
    if (LED !== exp_entry) begin
      errors++;
      $display("FAIL press_entry: got %h want %h", LED, exp_entry);
    end
  endtask

  task automatic release_button();
    BUTTON = 1'b0;
    repeat (16) @(negedge CLK);
  endtask

  // Follows n_steps SCAN steps against the model, checking every cycle.
  task automatic run_scan(input int n_steps);
    int   steps;
    int   guard;
    logic t_prev;
    steps = 0;
    guard = 0;
    while (steps < n_steps && guard < 200) begin
      t_prev = TICK;
      @(negedge CLK);
      guard++;
      if (t_prev) begin
        if (scan_left) begin
          if (exp_led == 8'h80) begin exp_led = 8'h40; scan_left = 1'b0; end
          else exp_led = exp_led << 1;
        end else begin
          if (exp_led == 8'h01) begin exp_led = 8'h02; scan_left = 1'b1; end
          else exp_led = exp_led >> 1;
        end
        steps++;
      end
      checks++;
      if (LED !== exp_led) begin
        errors++;
        $display("FAIL scan_led: got %h want %h (step %0d)", LED, exp_led, steps);
      end
      checks++;
      if ($countones(LED) != 1) begin
        errors++;
        $display("FAIL scan_onehot: got %h want one bit set", LED);
      end
    end
    checks++;
    if (steps != n_steps) begin
      errors++;
      $display("FAIL scan_timeout: got %0d steps want %0d", steps, n_steps);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    BUTTON = 1'b0;
    SW = 4'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", LED); end
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", MODE); end
    checks++;
    if (TICK !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", TICK); end
    RST = 1'b0;
  endtask

  // Starts on the falling edge where reset was released.
  task automatic test_count();
    int cyc;
    int ticks;
    int last;
    cyc = 0; ticks = 0; last = 0;
    while (ticks < 260 && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      if (TICK) begin
        ticks++;
        if (ticks == 1) begin
          checks++;
          if (cyc != 4) begin errors++; $display("FAIL first_tick: got cycle %0d want 4", cyc); end
        end else if (ticks <= 5) begin
          checks++;
          if (cyc - last != 4) begin errors++; $display("FAIL tick_period: got %0d want 4", cyc - last); end
        end
        last = cyc;
      end
    end
    checks++;
    if (ticks != 260) begin errors++; $display("FAIL count_timeout: got %0d ticks want 260", ticks); end
    @(negedge CLK);
    checks++;
    if (LED !== 8'h04) begin errors++; $display("FAIL count_wrap: got %h want 04", LED); end
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL count_mode: got %0d want 0", MODE); end
  endtask

  task automatic test_scan();
    do_reset(1'b0);
    repeat (8) @(negedge CLK);
    press(2'd1, 8'h01);
    exp_led = 8'h01;
    scan_left = 1'b1;
    run_scan(14);
    release_button();
  endtask

  task automatic test_reset_mid_scan();
    do_reset(1'b0);
    repeat (8) @(negedge CLK);
    press(2'd1, 8'h01);
    exp_led = 8'h01;
    scan_left = 1'b1;
    run_scan(3);
    BUTTON = 1'b0;
    #2 RST = 1'b1;
    #1;
    checks++;
    if (LED !== 8'h00) begin errors++; $display("FAIL async_reset_led: got %h want 00", LED); end
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL async_reset_mode: got %0d want 0", MODE); end
    checks++;
    if (TICK !== 1'b0) begin errors++; $display("FAIL async_reset_tick: got %b want 0", TICK); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_button_held_reset();
    do_reset(1'b1);
    repeat (40) @(negedge CLK);
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL held_reset_mode: got %0d want 0", MODE); end
    BUTTON = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL held_release_mode: got %0d want 0", MODE); end
    press(2'd1, 8'h01);
    release_button();
  endtask

`ifdef LED_PATTERN_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset(1'b0);
    repeat (8) @(negedge CLK);
    BUTTON = 1'b1;
    repeat (4) @(negedge CLK);
    BUTTON = 1'b0;
    repeat (30) @(negedge CLK);
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL glitch_mode: got %0d want 0", MODE); end
    press(2'd1, 8'h01);
    repeat (8) @(negedge CLK);
    release_button();
    checks++;
    if (MODE !== 2'd1) begin errors++; $display("FAIL held_once_mode: got %0d want 1", MODE); end
  endtask

  task automatic test_coincidence();
    logic t_prev;
    int   n;
    do_reset(1'b0);
    repeat (10) @(negedge CLK);
    BUTTON = 1'b1;
    t_prev = 1'b0;
    n = 0;
    while (MODE === 2'd0 && n < 60) begin
      t_prev = TICK;
      @(negedge CLK);
      n++;
    end
    checks++;
    if (t_prev !== 1'b1) begin errors++; $display("FAIL coinc_tick: got %b want 1", t_prev); end
    checks++;
    if (MODE !== 2'd1) begin errors++; $display("FAIL coinc_mode: got %0d want 1", MODE); end
    checks++;
    if (LED !== 8'h01) begin errors++; $display("FAIL coinc_led: got %h want 01", LED); end
  endtask
`else
  task automatic test_press_latency();
    do_reset(1'b0);
    repeat (8) @(negedge CLK);
    BUTTON = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      checks++;
      if (MODE !== 2'd0) begin errors++; $display("FAIL latency_early: got %0d want 0 (cycle %0d)", MODE, i); end
    end
    @(negedge CLK);
    checks++;
    if (MODE !== 2'd1) begin errors++; $display("FAIL latency_mode: got %0d want 1", MODE); end
    checks++;
    if (LED !== 8'h01) begin errors++; $display("FAIL latency_led: got %h want 01", LED); end
    release_button();
  endtask

  // The press event lands three cycles after BUTTON rises, so raising it one
  // cycle after a TICK puts the event on the next TICK.
  task automatic test_coincidence();
    int n;
    do_reset(1'b0);
    repeat (10) @(negedge CLK);
    n = 0;
    while (TICK !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    BUTTON = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (TICK !== 1'b1) begin errors++; $display("FAIL coinc_tick: got %b want 1", TICK); end
    @(negedge CLK);
    checks++;
    if (MODE !== 2'd1) begin errors++; $display("FAIL coinc_mode: got %0d want 1", MODE); end
    checks++;
    if (LED !== 8'h01) begin errors++; $display("FAIL coinc_led: got %h want 01", LED); end
  endtask
`endif

  // Continues from SCAN left by test_coincidence.
  task automatic test_pause_blink();
    int ticks;
    int guard;
    release_button();
    SW = 4'h1;
    repeat (4) @(negedge CLK);
    press(2'd2, 8'h00);
    ticks = 0;
    guard = 0;
    while (ticks < 10 && guard < 100) begin
      @(negedge CLK);
      guard++;
      if (TICK) ticks++;
      checks++;
      if (LED !== 8'h00) begin errors++; $display("FAIL pause_led: got %h want 00", LED); end
    end
    checks++;
    if (ticks != 10) begin errors++; $display("FAIL pause_timeout: got %0d ticks want 10", ticks); end
    SW = 4'h0;
    release_button();
  endtask

  task automatic test_mirror_wrap();
    do_reset(1'b0);
    SW = 4'hA;
    repeat (8) @(negedge CLK);
    press(2'd1, 8'h01);
    release_button();
    press(2'd2, 8'h00);
    release_button();
    press(2'd3, 8'hAA);
    release_button();
    checks++;
    if (LED !== 8'hAA) begin errors++; $display("FAIL mirror_hold: got %h want aa", LED); end
    SW = 4'h5;
    repeat (3) @(negedge CLK);
    checks++;
    if (LED !== 8'h55) begin errors++; $display("FAIL mirror_follow: got %h want 55", LED); end
    SW = 4'hA;
    repeat (4) @(negedge CLK);
    press(2'd0, 8'h00);
    release_button();
  endtask

  initial begin
    test_reset();
    test_count();
    test_scan();
    test_reset_mid_scan();
    test_button_held_reset();
`ifdef LED_PATTERN_DEBOUNCE_EN
    test_debounce();
`else
    test_press_latency();
`endif
    test_coincidence();
    test_pause_blink();
    test_mirror_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_BITS, default 16, tick prescaler width (tick period 2^PRESCALE_BITS CLK cycles; min 2).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, consecutive stable tick samples needed to accept a button level (min 2, max 15).
REQ-003 SHALL have port CLK  input  1  single clock for all logic.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port BUTTON  input  1  raw pushbutton, active-high, asynchronous to CLK.
REQ-006 SHALL have port SW  input  4  slide switches, asynchronous to CLK.
REQ-007 SHALL have port LED  output  8  registered LED pattern.
REQ-008 SHALL have port MODE  output  2  registered current mode (0 COUNT, 1 SCAN, 2 BLINK, 3 MIRROR).
REQ-009 SHALL have port TICK  output  1  one-CLK-cycle pulse at each prescaler wrap.

Function
REQ-010 SHALL run a free-running PRESCALE_BITS-bit prescaler and assert TICK for exactly one cycle when it wraps from all-ones to 0.
REQ-011 SHALL pass BUTTON and SW each through a 2-flop synchronizer before any use.
REQ-012 SHALL generate a one-cycle press event on each 0->1 transition of the accepted button level; releases generate no event.
REQ-013 SHALL implement the mode FSM COUNT->SCAN->BLINK->MIRROR->COUNT, advancing one state per press event and updating MODE on the cycle after the event.
REQ-014 SHALL load the entry value of the new mode into LED on that same update cycle: COUNT 0x00, SCAN 0x01 with direction left, BLINK 0x00, MIRROR {sw,sw}.
REQ-015 SHALL, in COUNT, increment LED by one per TICK, wrapping 0xFF->0x00.
REQ-016 SHALL, in SCAN, shift the single lit bit one position per TICK; direction reverses at 0x80 (to right) and at 0x01 (to left); LED always has exactly one bit set.
REQ-017 SHALL, in BLINK, toggle LED between 0x00 and 0xFF per TICK.
REQ-018 SHALL, in MIRROR, drive LED = {sw_sync, sw_sync} every cycle regardless of TICK (one cycle after the synchronized value).
REQ-019 SHALL, when synchronized SW[0]=1 in COUNT, SCAN or BLINK, hold LED (pause); the prescaler and FSM keep running.
REQ-020 SHALL, when a press event and TICK coincide, apply the mode change and entry value only; that TICK's pattern step is discarded.

Reset
REQ-021 SHALL, while RST=1, asynchronously force LED=0x00, MODE=0 (COUNT), TICK=0, prescaler=0, synchronizers=0, debounce state=0 (released), scan direction left.
REQ-022 SHALL, on RST deassertion, resume in COUNT with the first TICK 2^PRESCALE_BITS cycles later; reset asserted mid-pattern or mid-debounce discards all progress.
REQ-023 SHALL NOT generate a press event on the first cycles after reset, even if BUTTON is held high across reset release.

Configuration
REQ-024 SHALL, with LED_PATTERN_DEBOUNCE_EN defined, accept a new button level only after DEBOUNCE_TICKS consecutive TICK samples of the synchronized BUTTON all equal that level; any mismatching sample restarts the count.
REQ-025 SHALL, without LED_PATTERN_DEBOUNCE_EN, use the synchronized BUTTON directly as the accepted level (press event 3 cycles after BUTTON rises); no debounce logic is present.

Verification (PRESCALE_BITS=2, DEBOUNCE_TICKS=2)
REQ-026 SHALL verify reset: RST=1 mid-SCAN with LED=0x08 -> LED=0x00, MODE=0, TICK=0 immediately, without a CLK edge.
REQ-027 SHALL verify COUNT: 260 ticks after reset, SW=0 -> LED=0x04 (wrapped), TICK period 4 cycles.
REQ-028 SHALL verify SCAN: one press, 14 ticks -> LED sequence 0x01,0x02..0x80,0x40..0x01, with a single bit set throughout.
REQ-029 SHALL verify debounce (macro defined): BUTTON glitch high for 1 tick then low -> MODE unchanged; held 2 ticks -> MODE advances by exactly 1.
REQ-030 SHALL verify coincidence and pause: press event on a TICK cycle in COUNT -> MODE=1, LED=0x01, no shift; in BLINK with SW=0x1 -> LED constant for 10 ticks.
REQ-031 SHALL verify MIRROR and wrap: 3 presses, SW=0xA -> LED=0xAA; 4th press -> MODE=0, LED=0x00.
